// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between the IFU and the LSU.
// One transaction is outstanding at a time. It is granted in IDLE, then timed
// in WAIT for MEM_LAT cycles. The response is then routed to its owner.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration when both
// requesters are active. When it is undefined, the LSU has fixed priority.
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 64,
   parameter int MEM_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [DATA_W/8-1:0] ls_strb,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_strb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;
   typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

   state_t           state, state_nxt;
   owner_t           owner, owner_nxt;
   logic             op_we, op_we_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             pick_lsu;   // arbitration winner when any request is pending

`ifdef MEM_ARB_RR_EN
   owner_t last, last_nxt;

   // Round-robin on a tie: the requester that did not win last time wins now.
   always_comb begin
      pick_lsu = ls_req;
      if (ls_req && if_req) pick_lsu = (last == OWN_IFU);
   end

   // last follows every grant. A grant can only happen in IDLE with a request pending.
   assign last_nxt = (state == ST_IDLE && (ls_req || if_req))
                     ? (pick_lsu ? OWN_LSU : OWN_IFU) : last;

   // Remember the previous winner. After reset the first tie goes to the LSU.
   always_ff @(posedge clk) begin
      if (!rst) last <= OWN_IFU;
      else      last <= last_nxt;
   end
`else
   assign pick_lsu = ls_req;
`endif

   // State, owner, operation type and latency counter registers.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         owner <= OWN_IFU;
         op_we <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         op_we <= op_we_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic plus grant, memory-strobe and response outputs.
   // All outputs are held at zero while reset is asserted.
   // NOTE: every output is given a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      op_we_nxt = op_we;
      cnt_nxt   = cnt;
      if_gnt    = 1'b0;
      ls_gnt    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_strb  = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if_rvalid = 1'b0;
      if_rdata  = '0;
      ls_rvalid = 1'b0;
      ls_rdata  = '0;
      busy      = 1'b0;

      if (rst) begin
         case (state)
            ST_IDLE: begin
               if (ls_req || if_req) begin
                  mem_en    = 1'b1;
                  state_nxt = ST_WAIT;
                  cnt_nxt   = CNT_W'(1);
                  if (pick_lsu) begin
                     ls_gnt    = 1'b1;
                     mem_we    = ls_we;
                     mem_strb  = ls_strb;
                     mem_addr  = ls_addr;
                     mem_wdata = ls_wdata;
                     owner_nxt = OWN_LSU;
                     op_we_nxt = ls_we;
                  end else begin
                     if_gnt    = 1'b1;
                     mem_addr  = if_addr;
                     owner_nxt = OWN_IFU;
                     op_we_nxt = 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               busy    = 1'b1;
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(MEM_LAT)) begin
                  state_nxt = ST_IDLE;
                  if (owner == OWN_LSU) begin
                     ls_rvalid = 1'b1;
                     ls_rdata  = op_we ? '0 : mem_rdata;
                  end else begin
                     if_rvalid = 1'b1;
                     if_rdata  = mem_rdata;
                  end
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
// A transaction-level reference model predicts grants, memory strobes, busy,
// and the responses that are due. A monitor pops the responses as they come back.
// Define MEM_ARB_RR_EN for both the bench and the RTL to check the round-robin build.
module tb_mem_arbiter;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 64;
   localparam int MEM_LAT = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req, ls_req, ls_we;
   logic [ADDR_W-1:0] if_addr, ls_addr;
   logic [7:0]        ls_strb;
   logic [DATA_W-1:0] ls_wdata;
   logic              if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
   logic [DATA_W-1:0] if_rdata, ls_rdata, mem_wdata, mem_rdata;
   logic [7:0]        mem_strb;
   logic [ADDR_W-1:0] mem_addr;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_strb(ls_strb), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_strb(mem_strb), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [63:0] init_word(input int a);
      logic [15:0] w;
      w = 16'(a);
      return (a == 8) ? 64'h0 : {16'hC0DE, w, ~w, 16'h5A5A};
   endfunction

   // Environment memory: synchronous, and read data appears MEM_LAT (=2) cycles after the access.
   logic [63:0] env_mem [0:63];
   logic [63:0] pipe1, pipe2;
   assign mem_rdata = pipe2;
   always @(posedge clk) begin
      if (mem_en && mem_we)
         for (int b = 0; b < 8; b++)
            if (mem_strb[b]) env_mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      pipe1 <= env_mem[mem_addr[5:0]];
      pipe2 <= pipe1;
   end

   // Reference model state.
   typedef struct {
      bit          lsu;
      logic [63:0] data;
      int          due;
   } rsp_t;
   rsp_t        sb_q[$];
   logic [63:0] ref_mem [0:63];
   int          free_at  = 0;   // first cycle in which arbitration is open again
   bit          last_lsu = 1'b0;

   initial for (int a = 0; a < 64; a++) begin
      env_mem[a] = init_word(a);
      ref_mem[a] = init_word(a);
   end

   // Predictor: decides who should win this cycle from the request rules alone.
   int          win;            // 0 none, 1 IFU, 2 LSU
   bit          busy_e;
   logic [89:0] bus_e;
   logic [63:0] rsp_d;
   always @(negedge clk) begin
      if (!rst) begin
         check("gnt_in_reset", {if_gnt, ls_gnt}, 2'b00);
         check("mem_in_reset", {mem_en, mem_we, mem_strb, mem_addr, mem_wdata}, '0);
         check("busy_in_reset", busy, 1'b0);
         sb_q.delete();
         free_at  = cyc + 1;
         last_lsu = 1'b0;
      end else begin
         busy_e = (cyc < free_at);
         win    = 0;
         if (!busy_e) begin
            if (ls_req && if_req) begin
`ifdef MEM_ARB_RR_EN
               win = last_lsu ? 1 : 2;
`else
               win = 2;
`endif
            end else if (ls_req) win = 2;
            else if (if_req)     win = 1;
         end
         bus_e = '0;
         if (win == 2) bus_e = {1'b1, ls_we, ls_strb, ls_addr, ls_wdata};
         if (win == 1) bus_e = {1'b1, 1'b0, 8'h00, if_addr, 64'h0};
         check("grant", {if_gnt, ls_gnt}, {win == 1, win == 2});
         check("mem_bus", {mem_en, mem_we, mem_strb, mem_addr, mem_wdata}, bus_e);
         check("busy", busy, busy_e);
         if (win != 0) begin
            if (win == 2 && ls_we) begin
               for (int b = 0; b < 8; b++)
                  if (ls_strb[b]) ref_mem[ls_addr[5:0]][8*b +: 8] = ls_wdata[8*b +: 8];
               rsp_d = 64'h0;
            end else begin
               rsp_d = (win == 2) ? ref_mem[ls_addr[5:0]] : ref_mem[if_addr[5:0]];
            end
            sb_q.push_back('{lsu: (win == 2), data: rsp_d, due: cyc + MEM_LAT});
            free_at  = cyc + MEM_LAT + 1;
            last_lsu = (win == 2);
         end
      end
   end

   // Monitor: compares response ports with the head of the scoreboard when it is due.
   rsp_t        head;
   logic [129:0] rsp_e;
   always @(negedge clk) begin
      if (!rst) begin
         check("rsp_in_reset", {if_rvalid, if_rdata, ls_rvalid, ls_rdata}, '0);
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
         head  = sb_q.pop_front();
         rsp_e = head.lsu ? {1'b0, 64'h0, 1'b1, head.data} : {1'b1, head.data, 1'b0, 64'h0};
         check(head.due == cyc ? "response" : "response_late",
               {if_rvalid, if_rdata, ls_rvalid, ls_rdata}, rsp_e);
      end else begin
         check("no_response", {if_rvalid, if_rdata, ls_rvalid, ls_rdata}, '0);
      end
   end

   // Driver helpers: a granted requester drops its request unless hold is set.
   bit          ifu_g, lsu_g, ls_seen;
   logic [63:0] ls_seen_data;
   task automatic step(input bit hold);
      @(negedge clk);
      ifu_g = if_gnt;
      lsu_g = ls_gnt;
      if (ls_rvalid) begin
         ls_seen      = 1'b1;
         ls_seen_data = ls_rdata;
      end
      @(posedge clk);
      #1;
      if (!hold && ifu_g) if_req = 1'b0;
      if (!hold && lsu_g) ls_req = 1'b0;
   endtask

   task automatic run_out(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   task automatic lsu_issue(input bit we, input logic [7:0] strb, input int a, input logic [63:0] d);
      ls_req   = 1'b1;
      ls_we    = we;
      ls_strb  = strb;
      ls_addr  = 16'(a);
      ls_wdata = d;
   endtask

   initial begin
      rst = 1'b0; if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_strb = '0; ls_addr = '0; ls_wdata = '0;
      ls_seen = 1'b0; ls_seen_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Single fetch of 0x10.
      if_req = 1'b1; if_addr = 16'h10;
      run_out(5);

      // Contention: a fetch and a load of 0x20 arrive together.
      if_req = 1'b1; if_addr = 16'h11;
      lsu_issue(1'b0, 8'h00, 16'h20, 64'h0);
      run_out(8);

      // Both requesters are held continuously across several grants.
      if_req = 1'b1; if_addr = 16'h12;
      lsu_issue(1'b0, 8'h00, 16'h21, 64'h0);
      for (int i = 0; i < 12; i++) step(1'b1);
      if_req = 1'b0; ls_req = 1'b0;
      run_out(4);

      // Partial store over a zero word, then a load of the same word.
      lsu_issue(1'b1, 8'h0F, 16'h8, 64'h1122334455667788);
      run_out(4);
      ls_seen = 1'b0;
      lsu_issue(1'b0, 8'h00, 16'h8, 64'h0);
      run_out(4);
      check("load_rsp_seen", ls_seen, 1'b1);
      check("load_after_store", ls_seen_data, 64'h0000000055667788);

      // Fetch requested while an LSU transaction is in flight.
      lsu_issue(1'b0, 8'h00, 16'h3, 64'h0);
      step(1'b0);
      if_req = 1'b1; if_addr = 16'h4;
      run_out(6);

      // Reset in the middle of a fetch, then a load is granted right away.
      if_req = 1'b1; if_addr = 16'h5;
      step(1'b0);
      rst = 1'b0;
      step(1'b0);
      rst = 1'b1;
      lsu_issue(1'b0, 8'h00, 16'h6, 64'h0);
      run_out(5);

      // Randomized traffic with occasional reset pulses.
      for (int i = 0; i < 1500; i++) begin
         step(1'b0);
         rst = ($urandom_range(0, 99) != 0);
         if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req  = 1'b1;
            if_addr = 16'($urandom_range(0, 63));
         end
         if (!ls_req && $urandom_range(0, 2) == 0)
            lsu_issue($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 63),
                      {$urandom, $urandom});
      end
      rst = 1'b1;
      if_req = 1'b0; ls_req = 1'b0;
      run_out(6);
      check("scoreboard_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
